aurora_rx_block_decoder: RTL and testbench
==========================================

Name: aurora_rx_block_decoder

Overview:
- Sits directly downstream of aurora_rx_lane and consumes its descrambled 66-bit block stream (64-bit payload, 2-bit sync header, valid strobe, lock status).
- Qualifies the link with a DOWN/VERIFY/UP state machine and classifies each block as data or control.
- Discards idle control blocks and buffers the remaining blocks in a FIFO that presents a ready/valid stream to the channel logic.
- Maintains saturating error and drop counters for register readout.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW blocks.
- VERIFY_CNT, 64, consecutive legal blocks required to move from VERIFY to UP.
- ERR_WINDOW, 1024, block window used for error-rate link drop.
- ERR_MAX, 16, errors within one window that force the link DOWN.

Ports:
- clk_rx_i  in  1  block clock, same as the aurora_rx_lane output clock.
- rst_i  in  1  asynchronous, active-high reset.
- rx_data_i  in  64  block payload from the lane.
- rx_header_i  in  2  sync header: 2'b01 = data, 2'b10 = control.
- rx_valid_i  in  1  block strobe.
- rx_lock_i  in  1  lane header-lock status (rx_stat bit 0).
- clear_i  in  1  synchronous clear of counters and sticky flags.
- m_data_o  out  64  output block payload.
- m_ctrl_o  out  1  1 = control block, 0 = data block.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  output ready.
- link_up_o  out  1  high in state UP.
- err_cnt_o  out  16  saturating count of illegal blocks.
- drop_cnt_o  out  16  saturating count of blocks dropped on FIFO overflow.
- overflow_o  out  1  sticky; set on the first drop.

Behaviour:
- Reset values: all outputs 0, FSM = DOWN, FIFO empty, all counters 0.
- Illegal block (evaluated only when rx_valid_i = 1):
  - header 2'b00 or 2'b11; or
  - header 2'b10 with block type field rx_data_i[63:56] not in {IDLE 8'h78, SEP 8'h1E, SEP7 8'hE1, USER_K 8'hD2}.
- FSM:
  - DOWN -> VERIFY when rx_lock_i = 1.
  - VERIFY counts consecutive legal valid blocks. An illegal block resets the count to 0. At count = VERIFY_CNT -> UP.
  - UP tracks a block counter and an error counter. When the block counter reaches ERR_WINDOW, both counters reset to 0. Error counter reaching ERR_MAX -> DOWN.
  - rx_lock_i = 0 in any state -> DOWN on the next edge. Lock loss has priority over every other transition.
- Input stage: one register stage.
  - A legal block accepted in cycle N is written to the FIFO at edge N+1.
  - If the FIFO was empty, m_valid_o rises after edge N+2 (first-word-fall-through).
- Write qualification:
  - Writes happen only while in UP, and only for legal blocks that are not IDLE.
  - Control blocks are stored with m_ctrl_o = 1. Payload is stored unmodified.
- Handshake:
  - A pop occurs when m_valid_o && m_ready_i.
  - m_data_o and m_ctrl_o are held stable while m_valid_o = 1 and m_ready_i = 0.
- Full FIFO:
  - A write is dropped when count == depth, evaluated before any same-cycle pop.
  - Each drop increments drop_cnt_o and sets overflow_o.
  - A same-cycle pop still completes.
- Empty FIFO: m_valid_o = 0. A pop request is ignored.
- Leaving UP:
  - FIFO and input stage are flushed at the same edge.
  - m_valid_o = 0 from the next cycle.
  - Any in-flight block is discarded.
- Counters:
  - err_cnt_o increments on every illegal valid block while not in DOWN, and saturates at 16'hFFFF.
  - drop_cnt_o saturates at 16'hFFFF.
  - clear_i zeroes both counters and overflow_o. If an event and clear_i occur in the same cycle, clear wins.
- Pointers are FIFO_AW+1 bits. Full/empty are decided by MSB comparison, and wrap-around is exact at 2**FIFO_AW.
- Reset asserted mid-operation returns everything to reset values asynchronously.

Decomposition:
- Package aurora_rx_pkg holds:
  - header constants HDR_DATA = 2'b01, HDR_CTRL = 2'b10;
  - the block type constants above;
  - link_state_t enum {LS_DOWN, LS_VERIFY, LS_UP}.
- One natural sub-module: aurora_rx_block_fifo. It is a synchronous FWFT FIFO, 65 bits wide, with parameter FIFO_AW, a flush input, and full/empty/count outputs.
- The FSM, classifier and counters stay in the top module.

Test Plan:
- Link bring-up: raise rx_lock_i, then send 64 data blocks with payload {cnt,cnt}.
  - link_up_o rises after the 64th block.
  - Blocks sent after that appear on m_data_o in order, 2 cycles after input, with m_ctrl_o = 0.
- Idle filtering: in UP, interleave control blocks with type 8'h78 and 8'hD2.
  - Only the 8'hD2 blocks are output, with m_ctrl_o = 1.
  - err_cnt_o stays 0.
- Error-rate drop: in UP, inject 16 blocks with header 2'b11 within 1024 blocks.
  - link_up_o falls after the 16th.
  - err_cnt_o = 16.
  - m_valid_o = 0 on the next cycle.
- Window reset: inject 15 errors, then 1024 clean blocks, then 15 more errors.
  - Link stays UP.
  - err_cnt_o = 30.
- Overflow: hold m_ready_i = 0 with FIFO_AW = 4 and send 20 data blocks.
  - 16 blocks are stored; drop_cnt_o = 4; overflow_o = 1.
  - Releasing ready drains exactly blocks 0 to 15.
  - clear_i zeroes drop_cnt_o and overflow_o.
- Lock loss mid-stream: drop rx_lock_i while the FIFO holds 5 blocks.
  - link_up_o = 0 and the FIFO is empty next cycle.
  - Re-lock requires a fresh 64-block VERIFY.

Source files
------------

// File: rtl/aurora_rx_pkg.sv
// Shared constants and types for the Aurora 64B/66B receive block path.
// Header codes, control block types and the link qualification states.
package aurora_rx_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam logic [7:0] BT_IDLE   = 8'h78;
  localparam logic [7:0] BT_SEP    = 8'h1E;
  localparam logic [7:0] BT_SEP7   = 8'hE1;
  localparam logic [7:0] BT_USER_K = 8'hD2;

  typedef enum logic [1:0] {
    LS_DOWN   = 2'd0,
    LS_VERIFY = 2'd1,
    LS_UP     = 2'd2
  } link_state_t;

  function automatic logic ctrl_type_ok(input logic [7:0] block_type);
    case (block_type)
      BT_IDLE, BT_SEP, BT_SEP7, BT_USER_K: ctrl_type_ok = 1'b1;
      default:                             ctrl_type_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aurora_rx_block_fifo.sv
// First-word-fall-through FIFO: head entry is visible combinationally while not empty.
// A push into a full FIFO is refused even if a pop happens in the same cycle; flush wins over both.
module aurora_rx_block_fifo #(
  parameter int FIFO_AW = 4,
  parameter int WIDTH   = 65
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_dat,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_dat,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             push;
  logic             pop;

  // Extra pointer MSB separates the full and empty cases when the indices match.
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign rd_dat = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/aurora_rx_block_decoder.sv
// Link qualification, block classification, idle filtering and buffering of lane blocks.
// Two register stages from input to m_valid_o; overflowing blocks are dropped and counted.
module aurora_rx_block_decoder
  import aurora_rx_pkg::*;
#(
  parameter int FIFO_AW    = 4,
  parameter int VERIFY_CNT = 64,
  parameter int ERR_WINDOW = 1024,
  parameter int ERR_MAX    = 16
) (
  input  logic        clk_rx_i,
  input  logic        rst_i,
  input  logic [63:0] rx_data_i,
  input  logic [1:0]  rx_header_i,
  input  logic        rx_valid_i,
  input  logic        rx_lock_i,
  input  logic        clear_i,
  output logic [63:0] m_data_o,
  output logic        m_ctrl_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        link_up_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] drop_cnt_o,
  output logic        overflow_o
);

  localparam int VW = $clog2(VERIFY_CNT + 1);
  localparam int BW = $clog2(ERR_WINDOW + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(2 ** FIFO_AW);

  link_state_t   state;
  link_state_t   state_nxt;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] vcnt_nxt;
  logic [BW-1:0] blk_cnt;
  logic [BW-1:0] blk_cnt_nxt;
  logic [EW-1:0] win_err;
  logic [EW-1:0] win_err_nxt;

  logic [7:0]    blk_type;
  logic          illegal;
  logic          legal;
  logic          is_idle;
  logic          leave_up;

  logic          stage_vld;
  logic [63:0]   stage_data;
  logic          stage_ctrl;

  logic [64:0]   fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic          drop;

  assign blk_type = rx_data_i[63:56];

  always_comb begin
    illegal = 1'b0;
    if (rx_valid_i) begin
      if ((rx_header_i == 2'b00) || (rx_header_i == 2'b11))
        illegal = 1'b1;
      else if ((rx_header_i == HDR_CTRL) && !ctrl_type_ok(blk_type))
        illegal = 1'b1;
    end
  end

  assign legal   = rx_valid_i && !illegal;
  assign is_idle = (rx_header_i == HDR_CTRL) && (blk_type == BT_IDLE);

  always_comb begin
    state_nxt   = state;
    vcnt_nxt    = vcnt;
    blk_cnt_nxt = blk_cnt;
    win_err_nxt = win_err;
    if (!rx_lock_i) begin
      state_nxt   = LS_DOWN;
      vcnt_nxt    = '0;
      blk_cnt_nxt = '0;
      win_err_nxt = '0;
    end else begin
      case (state)
        LS_DOWN: begin
          state_nxt = LS_VERIFY;
          vcnt_nxt  = '0;
        end
        LS_VERIFY: begin
          if (illegal) begin
            vcnt_nxt = '0;
          end else if (legal) begin
            if (vcnt == VW'(VERIFY_CNT - 1)) begin
              state_nxt   = LS_UP;
              vcnt_nxt    = '0;
              blk_cnt_nxt = '0;
              win_err_nxt = '0;
            end else begin
              vcnt_nxt = vcnt + VW'(1);
            end
          end
        end
        LS_UP: begin
          if (rx_valid_i) begin
            // The error limit is tested before the window wrap so the final error always counts.
            if (illegal && (win_err == EW'(ERR_MAX - 1))) begin
              state_nxt   = LS_DOWN;
              blk_cnt_nxt = '0;
              win_err_nxt = '0;
            end else if (blk_cnt == BW'(ERR_WINDOW - 1)) begin
              blk_cnt_nxt = '0;
              win_err_nxt = '0;
            end else begin
              blk_cnt_nxt = blk_cnt + BW'(1);
              if (illegal) win_err_nxt = win_err + EW'(1);
            end
          end
        end
        default: state_nxt = LS_DOWN;
      endcase
    end
  end

  assign leave_up = (state == LS_UP) && (state_nxt != LS_UP);

  always_ff @(posedge clk_rx_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= LS_DOWN;
      vcnt    <= '0;
      blk_cnt <= '0;
      win_err <= '0;
    end else begin
      state   <= state_nxt;
      vcnt    <= vcnt_nxt;
      blk_cnt <= blk_cnt_nxt;
      win_err <= win_err_nxt;
    end
  end

  // A block is only staged when the link stays UP across this edge, so leaving UP discards it.
  always_ff @(posedge clk_rx_i or posedge rst_i) begin
    if (rst_i) begin
      stage_vld  <= 1'b0;
      stage_data <= '0;
      stage_ctrl <= 1'b0;
    end else begin
      stage_vld <= (state == LS_UP) && !leave_up && legal && !is_idle;
      if (legal) begin
        stage_data <= rx_data_i;
        stage_ctrl <= (rx_header_i == HDR_CTRL);
      end
    end
  end

  aurora_rx_block_fifo #(
    .FIFO_AW (FIFO_AW),
    .WIDTH   (65)
  ) u_fifo (
    .clk    (clk_rx_i),
    .rst    (rst_i),
    .flush  (leave_up),
    .wr_en  (stage_vld),
    .wr_dat ({stage_ctrl, stage_data}),
    .rd_en  (m_ready_i),
    .rd_dat (fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assert property (@(posedge clk_rx_i) disable iff (rst_i)
                   fifo_full == (fifo_count == DEPTH_CNT));

  assign drop = stage_vld && fifo_full && !leave_up;

  always_ff @(posedge clk_rx_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o  <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      err_cnt_o  <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (illegal && (state != LS_DOWN) && (err_cnt_o != 16'hFFFF))
        err_cnt_o <= err_cnt_o + 16'd1;
      if (drop && (drop_cnt_o != 16'hFFFF))
        drop_cnt_o <= drop_cnt_o + 16'd1;
      if (drop)
        overflow_o <= 1'b1;
    end
  end

  assign m_data_o  = fifo_rd[63:0];
  assign m_ctrl_o  = fifo_rd[64];
  assign m_valid_o = !fifo_empty;
  assign link_up_o = (state == LS_UP);

endmodule

// File: tb/tb_aurora_rx_block_decoder.sv
// Directed bench for aurora_rx_block_decoder: vector table for the UP stream plus link-level sequences.
module tb_aurora_rx_block_decoder;
  import aurora_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic [1:0]  hdr;
  logic        valid;
  logic        lock;
  logic        clear;
  logic [63:0] m_data;
  logic        m_ctrl;
  logic        m_valid;
  logic        ready;
  logic        link_up;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        ready;
    logic        exp_valid;
    logic        exp_ctrl;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  aurora_rx_block_decoder #(
    .FIFO_AW    (4),
    .VERIFY_CNT (64),
    .ERR_WINDOW (1024),
    .ERR_MAX    (16)
  ) dut (
    .clk_rx_i    (clk),
    .rst_i       (rst),
    .rx_data_i   (data),
    .rx_header_i (hdr),
    .rx_valid_i  (valid),
    .rx_lock_i   (lock),
    .clear_i     (clear),
    .m_data_o    (m_data),
    .m_ctrl_o    (m_ctrl),
    .m_valid_o   (m_valid),
    .m_ready_i   (ready),
    .link_up_o   (link_up),
    .err_cnt_o   (err_cnt),
    .drop_cnt_o  (drop_cnt),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] h, input logic [63:0] d);
    valid = v;
    hdr   = h;
    data  = d;
  endtask

  task automatic send(input logic [1:0] h, input logic [63:0] d);
    drive(1'b1, h, d);
    tick();
  endtask

  task automatic idle(input int n);
    drive(1'b0, HDR_DATA, 64'h0);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One cycle to leave DOWN, then exactly 64 legal blocks must be needed to reach UP.
  task automatic bring_up(input string tag);
    idle(1);
    for (int i = 0; i < 64; i++) begin
      send(HDR_DATA, {i[31:0], i[31:0]});
      if (i == 62) check({tag, "_up_before_64"}, 64'(link_up), 64'd0);
    end
    check({tag, "_up_after_64"}, 64'(link_up), 64'd1);
  endtask

  localparam logic [63:0] D0 = 64'h1111_2222_3333_0000;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_0001;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_0002;
  localparam logic [63:0] I0 = {8'h78, 56'h0};
  localparam logic [63:0] K1 = {8'hD2, 56'h00AB_CDEF_0123_45};
  localparam logic [63:0] S1 = {8'h1E, 56'h11_2233_4455_6677};
  localparam logic [63:0] S2 = {8'hE1, 56'h88_99AA_BBCC_DDEE};

  initial begin
    // Output after each row reflects the block presented one row earlier.
    vecs[0]  = '{1'b1, HDR_DATA, D0,    1'b1, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, HDR_DATA, D1,    1'b1, 1'b1, 1'b0, D0};
    vecs[2]  = '{1'b1, HDR_CTRL, I0,    1'b1, 1'b1, 1'b0, D1};
    vecs[3]  = '{1'b1, HDR_CTRL, K1,    1'b1, 1'b0, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, HDR_CTRL, I0,    1'b1, 1'b1, 1'b1, K1};
    vecs[5]  = '{1'b1, HDR_DATA, D2,    1'b1, 1'b0, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, HDR_DATA, 64'h0, 1'b1, 1'b1, 1'b0, D2};
    vecs[7]  = '{1'b1, HDR_CTRL, S1,    1'b1, 1'b0, 1'b0, 64'h0};
    vecs[8]  = '{1'b1, HDR_CTRL, S2,    1'b0, 1'b1, 1'b1, S1};
    vecs[9]  = '{1'b0, HDR_DATA, 64'h0, 1'b0, 1'b1, 1'b1, S1};
    vecs[10] = '{1'b0, HDR_DATA, 64'h0, 1'b1, 1'b1, 1'b1, S2};
    vecs[11] = '{1'b0, HDR_DATA, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0};

    rst = 1'b1; lock = 1'b0; clear = 1'b0; ready = 1'b1;
    drive(1'b0, HDR_DATA, 64'h0);
    tick(); tick();
    check("rst_link_up",  64'(link_up),  64'd0);
    check("rst_m_valid",  64'(m_valid),  64'd0);
    check("rst_m_data",   m_data,        64'h0);
    check("rst_m_ctrl",   64'(m_ctrl),   64'd0);
    check("rst_err_cnt",  64'(err_cnt),  64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();
    check("no_lock_link_up", 64'(link_up), 64'd0);

    lock = 1'b1;
    bring_up("first");

    for (int i = 0; i < 12; i++) begin
      ready = vecs[i].ready;
      drive(vecs[i].valid, vecs[i].hdr, vecs[i].data);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ctrl", i),  64'(m_ctrl),  64'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d_data", i),  m_data,       vecs[i].exp_data);
    end
    check("filter_err_cnt", 64'(err_cnt), 64'd0);
    check("filter_link_up", 64'(link_up), 64'd1);

    // Error-rate drop: the 16th error also flushes data buffered in the FIFO.
    for (int i = 0; i < 15; i++) send(2'b11, 64'(i));
    check("err15_link_up", 64'(link_up), 64'd1);
    check("err15_err_cnt", 64'(err_cnt), 64'd15);
    ready = 1'b0;
    send(HDR_DATA, 64'hDDDD_0000_0000_00AA);
    send(HDR_DATA, 64'hDDDD_0000_0000_00BB);
    check("pre_drop_m_valid", 64'(m_valid), 64'd1);
    send(2'b11, 64'h0);
    check("err16_link_up", 64'(link_up), 64'd0);
    check("err16_err_cnt", 64'(err_cnt), 64'd16);
    check("err16_m_valid", 64'(m_valid), 64'd0);
    idle(2);
    check("down_no_valid", 64'(m_valid), 64'd0);

    ready = 1'b1;
    bring_up("second");

    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("clear_err_cnt", 64'(err_cnt), 64'd0);

    // An illegal control type counts like a bad header.
    send(HDR_CTRL, {8'h55, 56'h0});
    for (int i = 0; i < 14; i++) send(2'b00, 64'(i));
    check("win_first15_err", 64'(err_cnt), 64'd15);
    for (int i = 0; i < 1024; i++) send(HDR_DATA, {32'hA5A5_0000, i[31:0]});
    for (int i = 0; i < 15; i++) send(2'b11, 64'(i));
    check("win_link_up", 64'(link_up), 64'd1);
    check("win_err_cnt", 64'(err_cnt), 64'd30);

    idle(2);
    ready = 1'b0;
    for (int i = 0; i < 20; i++) send(HDR_DATA, {32'hC0DE_0000, i[31:0]});
    idle(2);
    check("ovf_m_valid",  64'(m_valid),  64'd1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
    check("ovf_overflow", 64'(overflow), 64'd1);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_data", i), m_data, {32'hC0DE_0000, i[31:0]});
      tick();
    end
    check("drain_empty", 64'(m_valid), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);

    ready = 1'b0;
    for (int i = 0; i < 5; i++) send(HDR_DATA, {32'hBEEF_0000, i[31:0]});
    idle(2);
    check("lock_pre_valid", 64'(m_valid), 64'd1);
    check("lock_pre_data",  m_data,       {32'hBEEF_0000, 32'h0});
    lock = 1'b0;
    tick();
    check("lockloss_link_up", 64'(link_up), 64'd0);
    check("lockloss_m_valid", 64'(m_valid), 64'd0);
    lock = 1'b1;
    ready = 1'b1;
    bring_up("relock");

    ready = 1'b0;
    send(HDR_DATA, 64'h0123_4567_89AB_CDEF);
    send(2'b11, 64'h0);
    idle(1);
    check("pre_arst_valid", 64'(m_valid), 64'd1);
    check("pre_arst_err",   64'(err_cnt), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_link_up", 64'(link_up), 64'd0);
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_m_data",  m_data,       64'h0);
    check("arst_err_cnt", 64'(err_cnt), 64'd0);
    tick();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
